// File: rtl/taxi_ram_port_pkg.sv
// Shared types and sizing helpers for the taxi RAM port controller.
// The response entry layout below matches the default 16-bit data / 4-bit tag build.
package taxi_ram_port_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_TAG_W  = 4;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_TAG_W-1:0]  tag;
      logic                  wr;
   } rsp_entry_t;

   // Credit counter must hold the value DEPTH itself, hence the extra bit.
   function automatic int credit_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int entry_w(input int data_w, input int tag_w, input bit with_wr);
      return data_w + tag_w + (with_wr ? 1 : 0);
   endfunction

endpackage

// File: rtl/taxi_ram_port_rsp_fifo.sv
// First-word-fall-through response FIFO with registered storage.
// Pointers carry an extra MSB so full and empty are distinguishable.
module taxi_ram_port_rsp_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop = pop && !empty;

   // Output reads as zero while empty so idle response fields stay clean.
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/taxi_ram_port_ctrl.sv
// Valid/ready front end for one RAM port with credit-managed response FIFO.
// Optional write acknowledges are enabled with TAXI_RAM_PORT_CTRL_WR_ACK_EN.
module taxi_ram_port_ctrl
   import taxi_ram_port_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int STRB_W    = DATA_W/8,
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [STRB_W-1:0] req_strb,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              req_valid,
   output logic              req_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_wr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr_en,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [STRB_W-1:0] ram_wr_strb,
   input  logic [DATA_W-1:0] ram_rd_data
);

   localparam int CW = credit_w(RSP_DEPTH);
`ifdef TAXI_RAM_PORT_CTRL_WR_ACK_EN
   localparam int EW = entry_w(DATA_W, TAG_W, 1'b1);
`else
   localparam int EW = entry_w(DATA_W, TAG_W, 1'b0);
`endif

   logic             run;
   logic [CW-1:0]    outstanding;
   logic             accept;
   logic             take_credit;
   logic             rsp_pop;
   logic             pend;
   logic [TAG_W-1:0] pend_tag;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [EW-1:0]    push_data;
   logic [EW-1:0]    pop_data;

   // run holds req_ready low until the first clock after reset release.
   assign req_ready = run && (outstanding < CW'(RSP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign rsp_valid = !fifo_empty;
   assign rsp_pop   = rsp_valid && rsp_ready;

`ifdef TAXI_RAM_PORT_CTRL_WR_ACK_EN
   logic pend_wr;
   assign take_credit = accept;
   assign push_data   = {(pend_wr ? '0 : ram_rd_data), pend_tag, pend_wr};
   assign {rsp_data, rsp_tag, rsp_wr} = pop_data;
`else
   assign take_credit = accept && !req_wr;
   assign push_data   = {ram_rd_data, pend_tag};
   assign {rsp_data, rsp_tag} = pop_data;
   assign rsp_wr = 1'b0;
`endif

   // RAM drive is gated by accept so the port idles at zero.
   assign ram_en      = accept;
   assign ram_addr    = accept ? req_addr : '0;
   assign ram_wr_en   = accept && req_wr;
   assign ram_wr_data = accept ? req_data : '0;
   assign ram_wr_strb = accept ? req_strb : '0;

   // Credits make overflow impossible; the full check is a backstop only.
   assign fifo_push = pend && (!fifo_full || rsp_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         outstanding <= '0;
         pend        <= 1'b0;
         pend_tag    <= '0;
      end else begin
         run      <= 1'b1;
         pend     <= take_credit;
         pend_tag <= req_tag;
         case ({take_credit, rsp_pop})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

`ifdef TAXI_RAM_PORT_CTRL_WR_ACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_wr <= 1'b0;
      else        pend_wr <= req_wr;
   end
`endif

   taxi_ram_port_rsp_fifo #(
      .WIDTH (EW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (rsp_pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
